secuenciador_mux: RTL and testbench

Upstream sequencer for the registered 4:1 bit-selector stage.
- Accepts a 4-bit parallel word over a valid/ready handshake.
- Holds the word on `oData` and steps `oSelector` through 00→01→10→11, holding each value for a programmable number of cycles, so the downstream stage serialises the word LSB first.
- Flags selector-valid cycles and provides a one-cycle-delayed valid aligned with the downstream registered output.

---
 rtl/secuenciador_mux.sv | 95 +++++++++
 tb/tb_secuenciador_mux.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_mux.sv
// Upstream sequencer: latches a 4-bit word and walks oSelector 00..11 so the
// downstream registered 4:1 stage serialises the word LSB first.
module secuenciador_mux #(
    parameter int unsigned CICLOS_POR_BIT = 1,
    parameter int unsigned GUARDA         = 0
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic [3:0] iDato,
    input  logic       iValido,
    output logic       oListo,
    output logic [3:0] oData,
    output logic [1:0] oSelector,
    output logic       oBitValido,
    output logic       oValidoSalida,
    output logic       oFin,
    output logic       oOcupado
);

    typedef enum logic [1:0] {StIdle, StShift, StGuard} tEstado;

    localparam logic [3:0] FinBit    = 4'(CICLOS_POR_BIT - 1);
    localparam logic [3:0] PreFinBit = 4'(CICLOS_POR_BIT - 2);
    localparam logic [3:0] FinGuarda = 4'(GUARDA - 1);
    localparam bit         HayGuarda = (GUARDA > 0);
    localparam bit         UnCiclo   = (CICLOS_POR_BIT == 1);

    tEstado     estado;
    logic [3:0] contador;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            estado        <= StIdle;
            contador      <= '0;
            oListo        <= 1'b0;
            oData         <= '0;
            oSelector     <= '0;
            oBitValido    <= 1'b0;
            oValidoSalida <= 1'b0;
            oFin          <= 1'b0;
        end else begin
            oValidoSalida <= oBitValido;
            oFin          <= 1'b0;
            unique case (estado)
                StIdle: begin
                    if (oListo && iValido) begin
                        oData      <= iDato;
                        oSelector  <= 2'b00;
                        contador   <= '0;
                        oListo     <= 1'b0;
                        oBitValido <= 1'b1;
                        estado     <= StShift;
                    end else begin
                        oListo <= 1'b1;
                    end
                end
                StShift: begin
                    // oFin is registered, so it is raised one edge ahead of the
                    // last cycle of bit 3.
                    if (contador == FinBit) begin
                        contador <= '0;
                        if (oSelector != 2'b11) begin
                            oSelector <= oSelector + 2'd1;
                            oFin      <= UnCiclo && (oSelector == 2'b10);
                        end else begin
                            oBitValido <= 1'b0;
                            if (HayGuarda) begin
                                estado <= StGuard;
                            end else begin
                                estado <= StIdle;
                                oListo <= 1'b1;
                            end
                        end
                    end else begin
                        contador <= contador + 4'd1;
                        oFin     <= (oSelector == 2'b11) && (contador == PreFinBit);
                    end
                end
                StGuard: begin
                    if (contador == FinGuarda) begin
                        contador <= '0;
                        estado   <= StIdle;
                        oListo   <= 1'b1;
                    end else begin
                        contador <= contador + 4'd1;
                    end
                end
                default: estado <= StIdle;
            endcase
        end
    end

    assign oOcupado = (estado != StIdle);

endmodule

// File: tb/tb_secuenciador_mux.sv
// Bench for secuenciador_mux: three instances (N=1/G=0, N=3/G=2, N=2/G=0), each feeding
// a modelled registered 4:1 stage whose bits are scored against queued expectations.
module tb_secuenciador_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    logic       rstA, valA, listoA, bvA, vsA, finA, ocA, dsA;
    logic [3:0] datoA, dataA;
    logic [1:0] selA;
    logic       rstB, valB, listoB, bvB, vsB, finB, ocB, dsB;
    logic [3:0] datoB, dataB;
    logic [1:0] selB;
    logic       rstC, valC, listoC, bvC, vsC, finC, ocC, dsC;
    logic [3:0] datoC, dataC;
    logic [1:0] selC;

    logic qA[$];
    logic qB[$];
    logic qC[$];
    int finCntA = 0, finCntB = 0, finCntC = 0;
    int expFinA = 0, expFinB = 0, expFinC = 0;

    secuenciador_mux #(.CICLOS_POR_BIT(1), .GUARDA(0)) uA (
        .iClock(clk), .iReset(rstA), .iDato(datoA), .iValido(valA), .oListo(listoA),
        .oData(dataA), .oSelector(selA), .oBitValido(bvA), .oValidoSalida(vsA),
        .oFin(finA), .oOcupado(ocA)
    );
    secuenciador_mux #(.CICLOS_POR_BIT(3), .GUARDA(2)) uB (
        .iClock(clk), .iReset(rstB), .iDato(datoB), .iValido(valB), .oListo(listoB),
        .oData(dataB), .oSelector(selB), .oBitValido(bvB), .oValidoSalida(vsB),
        .oFin(finB), .oOcupado(ocB)
    );
    secuenciador_mux #(.CICLOS_POR_BIT(2), .GUARDA(0)) uC (
        .iClock(clk), .iReset(rstC), .iDato(datoC), .iValido(valC), .oListo(listoC),
        .oData(dataC), .oSelector(selC), .oBitValido(bvC), .oValidoSalida(vsC),
        .oFin(finC), .oOcupado(ocC)
    );

    // Model of the downstream registered 4:1 bit selector.
    always_ff @(posedge clk) begin
        dsA <= dataA[selA];
        dsB <= dataB[selB];
        dsC <= dataC[selC];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushA(input logic [3:0] w);
        for (int b = 0; b < 4; b++) qA.push_back(w[b]);
    endtask
    task automatic pushB(input logic [3:0] w);
        for (int b = 0; b < 4; b++) repeat (3) qB.push_back(w[b]);
    endtask
    task automatic pushC(input logic [3:0] w);
        for (int b = 0; b < 4; b++) repeat (2) qC.push_back(w[b]);
    endtask

    // Advance one cycle, then score any downstream bit flagged by oValidoSalida.
    task automatic tick();
        @(negedge clk);
        if (finA === 1'b1) finCntA++;
        if (finB === 1'b1) finCntB++;
        if (finC === 1'b1) finCntC++;
        if (vsA === 1'b1) begin
            check("A sb nonempty", 32'(qA.size() != 0), 32'd1);
            if (qA.size() != 0) check("A serial bit", 32'(dsA), 32'(qA.pop_front()));
        end
        if (vsB === 1'b1) begin
            check("B sb nonempty", 32'(qB.size() != 0), 32'd1);
            if (qB.size() != 0) check("B serial bit", 32'(dsB), 32'(qB.pop_front()));
        end
        if (vsC === 1'b1) begin
            check("C sb nonempty", 32'(qC.size() != 0), 32'd1);
            if (qC.size() != 0) check("C serial bit", 32'(dsC), 32'(qC.pop_front()));
        end
    endtask

    logic [3:0] words [4];

    initial begin
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hF; words[3] = 4'h0;
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        valA = 1'b0; valB = 1'b0; valC = 1'b0;
        datoA = '0;  datoB = '0;  datoC = '0;
        tick();
        tick();
        check("rst listo", 32'(listoA), 0);
        check("rst data", 32'(dataA), 0);
        check("rst sel", 32'(selA), 0);
        check("rst bitvalido", 32'(bvA), 0);
        check("rst validosalida", 32'(vsA), 0);
        check("rst fin", 32'(finA), 0);
        check("rst ocupado", 32'(ocA), 0);

        // Test 1 (also handshake edge case: valid held while oListo rises)
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        datoA = 4'b1011; valA = 1'b1;
        tick();
        check("t1 listo rises", 32'(listoA), 1);
        check("t1 no early xfer", 32'(ocA), 0);
        tick();
        pushA(4'b1011); expFinA++;
        valA = 1'b0;
        check("t1 data", 32'(dataA), 32'hB);
        for (int k = 0; k < 4; k++) begin
            check("t1 sel", 32'(selA), 32'(k));
            check("t1 bitvalido", 32'(bvA), 1);
            check("t1 fin", 32'(finA), 32'(k == 3));
            check("t1 listo low", 32'(listoA), 0);
            tick();
        end
        check("t1 listo back", 32'(listoA), 1);
        check("t1 bitvalido off", 32'(bvA), 0);
        check("t1 sel holds 11", 32'(selA), 3);
        check("t1 fin off", 32'(finA), 0);
        repeat (2) tick();

        // Test 2: N=3, G=2
        check("t2 ready", 32'(listoB), 1);
        datoB = 4'b0110; valB = 1'b1;
        tick();
        pushB(4'b0110); expFinB++;
        valB = 1'b0;
        datoB = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            check("t2 bitvalido", 32'(bvB), 1);
            check("t2 sel", 32'(selB), 32'(i / 3));
            check("t2 fin", 32'(finB), 32'(i == 11));
            check("t2 listo low", 32'(listoB), 0);
            check("t2 data stable", 32'(dataB), 32'h6);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            check("t2 guard bitvalido", 32'(bvB), 0);
            check("t2 guard listo", 32'(listoB), 0);
            check("t2 guard ocupado", 32'(ocB), 1);
            tick();
        end
        check("t2 listo after guard", 32'(listoB), 1);
        check("t2 idle", 32'(ocB), 0);
        repeat (2) tick();

        // Test 3: input ignored while busy
        datoA = 4'b1001; valA = 1'b1;
        tick();
        pushA(4'b1001); expFinA++;
        datoA = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            check("t3 data held", 32'(dataA), 32'h9);
            check("t3 listo low", 32'(listoA), 0);
            tick();
        end
        check("t3 listo", 32'(listoA), 1);
        check("t3 data still", 32'(dataA), 32'h9);
        tick();
        pushA(4'b0110); expFinA++;
        valA = 1'b0;
        check("t3 second data", 32'(dataA), 32'h6);
        check("t3 second sel", 32'(selA), 0);
        check("t3 second bv", 32'(bvA), 1);
        repeat (5) tick();

        // Test 4: reset mid-SHIFT, N=2
        datoC = 4'b1101; valC = 1'b1;
        tick();
        valC = 1'b0;
        qC.push_back(1'b1); qC.push_back(1'b1); qC.push_back(1'b0); qC.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t4 sel", 32'(selC), 32'(i / 2));
            tick();
        end
        check("t4 sel 10", 32'(selC), 2);
        rstC = 1'b1;
        tick();
        rstC = 1'b0;
        check("t4 rst listo", 32'(listoC), 0);
        check("t4 rst data", 32'(dataC), 0);
        check("t4 rst sel", 32'(selC), 0);
        check("t4 rst bv", 32'(bvC), 0);
        check("t4 rst vs", 32'(vsC), 0);
        check("t4 rst fin", 32'(finC), 0);
        check("t4 rst ocupado", 32'(ocC), 0);
        tick();
        check("t4 listo after release", 32'(listoC), 1);
        datoC = 4'b0011; valC = 1'b1;
        tick();
        pushC(4'b0011); expFinC++;
        valC = 1'b0;
        check("t4 restart sel", 32'(selC), 0);
        check("t4 restart data", 32'(dataC), 32'h3);
        repeat (10) tick();

        // Test 5: continuous stream, N=1, G=0
        valA = 1'b1;
        for (int w = 0; w < 4; w++) begin
            datoA = words[w];
            check("t5 ready", 32'(listoA), 1);
            tick();
            pushA(words[w]); expFinA++;
            check("t5 data", 32'(dataA), 32'(words[w]));
            for (int i = 0; i < 4; i++) begin
                check("t5 listo low", 32'(listoA), 0);
                tick();
            end
        end
        valA = 1'b0;
        repeat (3) tick();

        // Test 6: handshake edge cases
        rstA = 1'b1;
        tick();
        check("t6 rst listo", 32'(listoA), 0);
        rstA = 1'b0; valA = 1'b1; datoA = 4'h7;
        tick();
        valA = 1'b0;
        check("t6 listo rises", 32'(listoA), 1);
        check("t6 no xfer", 32'(ocA), 0);
        check("t6 no bv", 32'(bvA), 0);
        tick();
        check("t6 still idle", 32'(ocA), 0);
        check("t6 data untouched", 32'(dataA), 0);
        valA = 1'b1; datoA = 4'h9;
        tick();
        valA = 1'b0;
        pushA(4'h9); expFinA++;
        check("t6 xfer ocupado", 32'(ocA), 1);
        check("t6 xfer data", 32'(dataA), 32'h9);
        check("t6 xfer sel", 32'(selA), 0);
        repeat (6) tick();

        check("A sb drained", 32'(qA.size()), 0);
        check("B sb drained", 32'(qB.size()), 0);
        check("C sb drained", 32'(qC.size()), 0);
        check("A fin count", 32'(finCntA), 32'(expFinA));
        check("B fin count", 32'(finCntB), 32'(expFinB));
        check("C fin count", 32'(finCntC), 32'(expFinC));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
